barrett_param_gen: RTL and testbench
====================================

BARRETT_PARAM_GEN -- requirements
Module: barrett_param_gen

Interface
REQ-001 SHALL have parameter Q_W, default 64, meaning modulus width in bits.
REQ-002 SHALL have parameter MU_W, default Q_W+2, meaning width of the mu output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request pulse; q is sampled in the same cycle.
REQ-006 SHALL have port q, input, Q_W, modulus.
REQ-007 SHALL have port busy, output, 1, high while a computation is in flight.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking that mu, k and err are valid.
REQ-009 SHALL have port mu, output, MU_W, Barrett constant floor(2^(2k)/q).
REQ-010 SHALL have port k, output, 8, bit length of q.
REQ-011 SHALL have port err, output, 1, set when q == 0.

Function
REQ-012 SHALL implement states IDLE, DIV and DONE; the unused state encoding SHALL return to IDLE.
REQ-013 IDLE with start=1 at edge N SHALL, on that edge, latch q, register k = index of the highest set bit of q plus 1, clear the remainder (Q_W+1 bits) and quotient (MU_W bits), load the bit counter with 2k, and enter DIV.
REQ-014 If q == 0 at start, the block SHALL instead go to DONE with err=1, k=0, mu=0.
REQ-015 In DIV, each edge SHALL process one dividend bit of 2^(2k), MSB first (bit 2k = 1, all others 0): rem' = {rem,bit}; if rem' >= q then subtract q and shift 1 into the quotient, else shift 0.
REQ-016 DIV SHALL last exactly 2k+1 cycles; on the edge that processes bit 0, mu SHALL take the final quotient and the state SHALL move to DONE.
REQ-017 done SHALL be high for exactly the one cycle the block is in DONE, which is 2k+1 cycles after the start edge (1 cycle when err), and the block SHALL then return to IDLE.
REQ-018 busy SHALL be high in DIV and DONE, and low in IDLE.
REQ-019 start SHALL be ignored while busy=1, and a new start SHALL be accepted in the cycle after done.
REQ-020 mu, k and err SHALL hold their last values until the next accepted start; err SHALL clear on any accepted start with q != 0.
REQ-021 Arithmetic SHALL be unsigned with no truncation: the remainder always fits in Q_W+1 bits, and the quotient (at most 2^(k+1)) fits in MU_W bits.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, mu=0, k=0 and err=0, including mid-DIV, with no completion pulse afterwards.
REQ-023 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-024 A shared barrett_pkg SHALL hold Q_W and MU_W defaults and the state encoding, shared with Barrett_Reduction.
REQ-025 The bit-length priority encoder SHALL be a separate combinational sub-module, barrett_bitlen (input Q_W bits, output 8-bit k).
REQ-026 mu and k SHALL be port-compatible with the Barrett_Reduction inputs; the low 31 bits of mu SHALL drive its mu port when Q_W <= 29.

Verification
REQ-027 q=768112, start pulse -> k=20, mu=1431447, done exactly 41 cycles after start, err=0.
REQ-028 q=1 -> k=1, mu=4, done 3 cycles after start; q=3 -> k=2, mu=5, done 5 cycles after start.
REQ-029 q=2^63 -> k=64, mu=2^65 (no overflow); q=2^64-1 -> k=64, mu=2^64+1, done 129 cycles after start.
REQ-030 q=0 -> done 1 cycle after start with err=1, mu=0, k=0; a following start with q=3 -> err cleared, mu=5.
REQ-031 start re-pulsed with a different q mid-DIV -> ignored, and the first result is unchanged; rst_n pulsed low mid-DIV -> all outputs 0 immediately, no done, and the next start computes correctly.

Source files
------------

// File: rtl/barrett_pkg.sv
// barrett_pkg
//   Shared definitions for the Barrett parameter generator and the
//   Barrett_Reduction datapath that consumes its mu/k outputs.
//   - Q_W_DEF / MU_W_DEF : default modulus and mu widths
//   - ST_*               : FSM state encoding of the parameter generator
package barrett_pkg;

    localparam int Q_W_DEF  = 64;
    localparam int MU_W_DEF = Q_W_DEF + 2;

    // Barrett_Reduction takes a 31-bit mu; valid when Q_W <= 29.
    localparam int RED_MU_W = 31;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/barrett_bitlen.sv
// barrett_bitlen
//   Combinational priority encoder: bit length of the modulus, i.e. the
//   index of the highest set bit plus one (0 when the input is 0).
//   Ports:
//     i_q [Q_W-1:0] : modulus
//     o_k [7:0]     : bit length
module barrett_bitlen #(
    parameter int Q_W = 64
) (
    input  logic [Q_W-1:0] i_q,
    output logic [7:0]     o_k
);

    // Scan LSB to MSB so the highest set bit wins.
    always_comb begin
        o_k = 8'd0;
        for (int i = 0; i < Q_W; i++) begin
            o_k = i_q[i] ? 8'(i + 1) : o_k;
        end
    end

endmodule

// File: rtl/barrett_param_gen.sv
// barrett_param_gen
//   Computes the Barrett constant mu = floor(2^(2k) / q) and k = bitlen(q)
//   with a bit-serial restoring divider (one dividend bit per cycle).
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     start, q       : request pulse and modulus (sampled together in IDLE)
//     busy           : computation in flight (DIV or DONE)
//     done           : one-cycle pulse, mu/k/err valid
//     mu [MU_W-1:0]  : Barrett constant
//     k  [7:0]       : bit length of q
//     err            : q was zero
module barrett_param_gen
    import barrett_pkg::*;
#(
    parameter int Q_W  = Q_W_DEF,
    parameter int MU_W = Q_W + 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [Q_W-1:0]  q,
    output logic            busy,
    output logic            done,
    output logic [MU_W-1:0] mu,
    output logic [7:0]      k,
    output logic            err
);

    logic [1:0]      r_state;
    logic [Q_W-1:0]  r_q;
    logic [7:0]      r_k;
    logic [8:0]      r_cnt;
    logic [Q_W:0]    r_rem;
    logic [MU_W-1:0] r_quo;
    logic [MU_W-1:0] r_mu;
    logic            r_err;
    logic            r_busy;
    logic            r_done;

    logic [7:0]      w_k;
    logic            w_bit;
    logic [Q_W:0]    w_rem_sh;
    logic            w_ge;
    logic [Q_W:0]    w_rem_nx;
    logic [MU_W-1:0] w_quo_nx;

    barrett_bitlen #(.Q_W(Q_W)) u_bitlen (
        .i_q (q),
        .o_k (w_k)
    );

    // One restoring-division step; the dividend 2^(2k) has only bit 2k set.
    // The remainder stays below q, so the shifted value fits in Q_W+1 bits.
    always_comb begin
        w_bit    = (r_cnt == {r_k, 1'b0}) ? 1'b1 : 1'b0;
        w_rem_sh = (r_rem << 1) | {{Q_W{1'b0}}, w_bit};
        w_ge     = (w_rem_sh >= {1'b0, r_q}) ? 1'b1 : 1'b0;
        w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_q}) : w_rem_sh;
        w_quo_nx = (r_quo << 1) | {{(MU_W-1){1'b0}}, w_ge};
    end

    // Control FSM, divider state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= {Q_W{1'b0}};
            r_k     <= 8'd0;
            r_cnt   <= 9'd0;
            r_rem   <= {(Q_W+1){1'b0}};
            r_quo   <= {MU_W{1'b0}};
            r_mu    <= {MU_W{1'b0}};
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_q    <= q;
                        r_k    <= w_k;
                        r_cnt  <= {w_k, 1'b0};
                        r_rem  <= {(Q_W+1){1'b0}};
                        r_quo  <= {MU_W{1'b0}};
                        r_busy <= 1'b1;
                        if (q == {Q_W{1'b0}}) begin
                            // Zero modulus: report straight away, no division.
                            r_err   <= 1'b1;
                            r_mu    <= {MU_W{1'b0}};
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= ST_DIV;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == 9'd0) begin
                        r_mu    <= w_quo_nx;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign mu   = r_mu;
    assign k    = r_k;
    assign err  = r_err;

endmodule

// File: tb/tb_barrett_param_gen.sv
// tb_barrett_param_gen
//   Directed vectors with hand-computed mu/k/err and done latency.
//   Latency is counted in rising edges after the start edge until done is
//   seen high: 2k+1 for a normal run, 0 for q == 0 (done appears in the
//   cycle right after the start edge).
module tb_barrett_param_gen;

    localparam int Q_W  = 64;
    localparam int MU_W = Q_W + 2;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [Q_W-1:0]  q;
    logic            busy;
    logic            done;
    logic [MU_W-1:0] mu;
    logic [7:0]      k;
    logic            err;

    int n_checks;
    int n_pass;

    barrett_param_gen #(.Q_W(Q_W), .MU_W(MU_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .q     (q),
        .busy  (busy),
        .done  (done),
        .mu    (mu),
        .k     (k),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start one computation; optionally re-pulse start with another q at
    // cycle glitch_at while busy (it must be ignored).
    task automatic run(input string tag, input logic [Q_W-1:0] qv,
                       input logic [7:0] exp_k, input logic [127:0] exp_mu,
                       input logic exp_err, input int exp_lat, input int glitch_at);
        int cycles;
        @(negedge clk);
        q     = qv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        q     = 64'd5;
        cycles = 0;
        chk({tag, " busy"}, {127'd0, busy}, 128'd1);
        while (!done && cycles < 300) begin
            if (cycles == glitch_at) begin
                start = 1'b1;
                q     = 64'd7;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
        end
        chk({tag, " latency"}, 128'(cycles), 128'(exp_lat));
        chk({tag, " mu"}, {62'd0, mu}, exp_mu);
        chk({tag, " k"}, {120'd0, k}, {120'd0, exp_k});
        chk({tag, " err"}, {127'd0, err}, {127'd0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, " done pulse"}, {127'd0, done}, 128'd0);
        chk({tag, " idle"}, {127'd0, busy}, 128'd0);
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        q        = 64'd0;
        #12;
        chk("reset busy", {127'd0, busy}, 128'd0);
        chk("reset done", {127'd0, done}, 128'd0);
        chk("reset mu", {62'd0, mu}, 128'd0);
        chk("reset k", {120'd0, k}, 128'd0);
        chk("reset err", {127'd0, err}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run("q768112", 64'd768112, 8'd20, 128'd1431447, 1'b0, 41, -1);
        run("q1", 64'd1, 8'd1, 128'd4, 1'b0, 3, -1);
        run("q3", 64'd3, 8'd2, 128'd5, 1'b0, 5, -1);
        run("q2p63", 64'h8000_0000_0000_0000, 8'd64, 128'd1 << 65, 1'b0, 129, -1);
        run("qmax", 64'hFFFF_FFFF_FFFF_FFFF, 8'd64, (128'd1 << 64) + 128'd1, 1'b0, 129, -1);
        run("q0", 64'd0, 8'd0, 128'd0, 1'b1, 0, -1);
        run("q3 after err", 64'd3, 8'd2, 128'd5, 1'b0, 5, -1);
        run("restart ignored", 64'd768112, 8'd20, 128'd1431447, 1'b0, 41, 6);

        // Reset in the middle of a division.
        @(negedge clk);
        q     = 64'd768112;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {127'd0, busy}, 128'd0);
        chk("midrst done", {127'd0, done}, 128'd0);
        chk("midrst mu", {62'd0, mu}, 128'd0);
        chk("midrst k", {120'd0, k}, 128'd0);
        chk("midrst err", {127'd0, err}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("midrst no done", 128'(done_seen), 128'd0);

        // First start right after reset release is taken on the first edge.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run("post reset q3", 64'd3, 8'd2, 128'd5, 1'b0, 5, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
